// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operation sequencer: command kinds, ALU opcodes and FSM states.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      CMD_ALU   = 2'b00,
      CMD_LOADI = 2'b01,
      CMD_READ  = 2'b10,
      CMD_NOP   = 2'b11
   } cmd_kind_e;

   // Encoding must match the external ALU's opcode input.
   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_RESP = 2'b10
   } seq_state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file: NREGS x ALU_WIDTH, two async read ports, one sync write port, R0 hardwired to zero.
module alu_seq_regfile #(
   parameter int ALU_WIDTH = 16,
   parameter int NREGS     = 8,
   localparam int RW       = $clog2(NREGS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [RW-1:0]        ra1,
   input  logic [RW-1:0]        ra2,
   output logic [ALU_WIDTH-1:0] rd1,
   output logic [ALU_WIDTH-1:0] rd2,
   input  logic                 we,
   input  logic [RW-1:0]        wa,
   input  logic [ALU_WIDTH-1:0] wd
);

   logic [ALU_WIDTH-1:0] mem [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (we && (wa != '0)) begin
         mem[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
   assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives an external combinational ALU from a small register file; commands in, results out
// over valid/ready streams, one command in flight at a time.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int ALU_WIDTH = 16,
   parameter int NREGS     = 8,
   localparam int RW       = $clog2(NREGS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_kind,
   input  logic [1:0]           cmd_op,
   input  logic [RW-1:0]        cmd_rd,
   input  logic [RW-1:0]        cmd_rs1,
   input  logic [RW-1:0]        cmd_rs2,
   input  logic [ALU_WIDTH-1:0] cmd_imm,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ALU_WIDTH-1:0] rsp_data,
   output logic                 rsp_zero,
   output logic [ALU_WIDTH-1:0] alu_a,
   output logic [ALU_WIDTH-1:0] alu_b,
   output logic [1:0]           alu_opcode,
   input  logic [ALU_WIDTH-1:0] alu_result,
   output logic [15:0]          op_count
);

   seq_state_e           state, state_nxt;
   cmd_kind_e            kind;
   logic                 accept;
   logic [RW-1:0]        rd_q;
   logic [ALU_WIDTH-1:0] rf_rd1, rf_rd2;
   logic                 rf_we;
   logic [RW-1:0]        rf_wa;
   logic [ALU_WIDTH-1:0] rf_wd;

   assign kind      = cmd_kind_e'(cmd_kind);
   assign cmd_ready = (state == S_IDLE);
   assign accept    = cmd_valid & cmd_ready;
   assign rsp_valid = (state == S_RESP);
   assign rsp_zero  = (rsp_data == '0);

   alu_seq_regfile #(
      .ALU_WIDTH (ALU_WIDTH),
      .NREGS     (NREGS)
   ) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (cmd_rs1),
      .ra2   (cmd_rs2),
      .rd1   (rf_rd1),
      .rd2   (rf_rd2),
      .we    (rf_we),
      .wa    (rf_wa),
      .wd    (rf_wd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Write port is shared: LOADI writes in the accept cycle, ALU writes back in EXEC.
   always_comb begin
      state_nxt = state;
      rf_we     = 1'b0;
      rf_wa     = rd_q;
      rf_wd     = alu_result;
      case (state)
         S_IDLE: begin
            if (accept) begin
               case (kind)
                  CMD_ALU:   state_nxt = S_EXEC;
                  CMD_LOADI: begin
                     rf_we     = 1'b1;
                     rf_wa     = cmd_rd;
                     rf_wd     = cmd_imm;
                     state_nxt = S_RESP;
                  end
                  CMD_READ:  state_nxt = S_RESP;
                  default:   state_nxt = S_IDLE;
               endcase
            end
         end
         S_EXEC: begin
            rf_we     = 1'b1;
            state_nxt = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= 2'b00;
         rd_q       <= '0;
         rsp_data   <= '0;
         op_count   <= '0;
      end else begin
         if (accept) begin
            case (kind)
               CMD_ALU: begin
                  alu_a      <= rf_rd1;
                  alu_b      <= rf_rd2;
                  alu_opcode <= cmd_op;
                  rd_q       <= cmd_rd;
               end
               CMD_LOADI: rsp_data <= cmd_imm;
               CMD_READ:  rsp_data <= rf_rd1;
               default: ;
            endcase
         end
         if (state == S_EXEC) begin
            rsp_data <= alu_result;
            op_count <= op_count + 16'd1;
         end
      end
   end

endmodule
